spi_burst_slave: RTL

SPI_BURST_SLAVE -- requirements
Module: spi_burst_slave

---
 rtl/spi_burst_slave.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_burst_slave.sv
// SPI mode-0 burst register slave: R/W bit, address, then auto-incrementing data words.
// SCLK, MOSI and SS are oversampled in the CLK domain; CLK must run at least 8x SCLK.
module spi_burst_slave #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS,
  output logic              MISO,
  output logic              MISO_OE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_EN,
  output logic              RD_EN,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              FRAME_ERR,
  output logic              BUSY
);
  localparam int         MAX_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int         CNT_W   = $clog2(MAX_W + 1);
  localparam logic [2:0] SETTLED = 3'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_WAIT_SS} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall, settled;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]          settle_q, settle_d;
  logic                rw_q, rw_d;
  logic                first_q, first_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-2:0]   data_sr_q, data_sr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   pre_q, pre_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_first_q, rd_first_d;
  logic                cap_q, cap_d;
  logic                cap_tx_q, cap_tx_d;
  logic                frame_err_q, frame_err_d;

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  assign ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS};

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  // The SS fall produced by flushing the preset synchroniser after reset must not start a frame.
  assign settled   = (settle_q == SETTLED);

  always_comb begin
    // NOTE: every _d defaults to its _q (or to 0 for strobes) first, so no path can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    settle_d    = settle_q;
    rw_d        = rw_q;
    first_d     = first_q;
    addr_d      = addr_q;
    data_sr_d   = data_sr_q;
    wr_data_d   = wr_data_q;
    tx_sr_d     = tx_sr_q;
    pre_d       = pre_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    rd_first_d  = 1'b0;
    frame_err_d = 1'b0;
    cap_d       = rd_en_q;
    cap_tx_d    = rd_first_q;

    if (!settled) settle_d = settle_q + 3'd1;
    if (cap_q) begin
      if (cap_tx_q) tx_sr_d = RD_DATA;
      else          pre_d   = RD_DATA;
    end
    // Writes hold ADDR through the WR_EN cycle and advance it afterwards.
    if (wr_en_q) addr_d = addr_q + ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (settled) begin
          if (ss_fall)    state_d = S_CMD;
          else if (!ss_s) state_d = S_WAIT_SS;
        end
      end
      S_CMD: begin
        if (ss_rise) state_d = S_IDLE;
        else if (sclk_rise) begin
          rw_d      = mosi_s;
          bit_cnt_d = '0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ss_rise) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          addr_d = {addr_q[ADDR_W-2:0], mosi_s};
          if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
            bit_cnt_d  = '0;
            first_d    = 1'b1;
            rd_en_d    = rw_q;
            rd_first_d = rw_q;
            state_d    = S_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (ss_rise) begin
          state_d     = S_IDLE;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          first_d   = 1'b0;
          data_sr_d = (DATA_W-1)'({data_sr_q, mosi_s});
          // Prefetch the next word's address while the current one is still shifting out.
          if (rw_q && bit_cnt_q == '0) begin
            rd_en_d = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
          end
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            wr_en_d   = ~rw_q;
            if (!rw_q) wr_data_d = {data_sr_q, mosi_s};
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && rw_q) begin
          if (bit_cnt_q != '0) tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
          else if (!first_q)   tx_sr_d = pre_q;
        end
      end
      S_WAIT_SS: begin
        if (ss_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      settle_q    <= '0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      addr_q      <= '0;
      data_sr_q   <= '0;
      wr_data_q   <= '0;
      tx_sr_q     <= '0;
      pre_q       <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_first_q  <= 1'b0;
      cap_q       <= 1'b0;
      cap_tx_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: <= makes every flop sample pre-edge values regardless of statement order.
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      settle_q    <= settle_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      addr_q      <= addr_d;
      data_sr_q   <= data_sr_d;
      wr_data_q   <= wr_data_d;
      tx_sr_q     <= tx_sr_d;
      pre_q       <= pre_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      rd_first_q  <= rd_first_d;
      cap_q       <= cap_d;
      cap_tx_q    <= cap_tx_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = (state_q == S_DATA) && rw_q && tx_sr_q[DATA_W-1];
  assign MISO_OE   = ~ss_s;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;
  assign WR_EN     = wr_en_q;
  assign RD_EN     = rd_en_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = (state_q != S_IDLE);
endmodule
